// File: rtl/pdm_uart_tx.sv
// PDM microphone capture to 8N1 UART streaming transmitter.
// Generates the PDM clock, packs 8 samples per byte (MSB first), buffers the
// bytes in a small synchronous FIFO and serialises them onto the tx line.
module pdm_uart_tx #(
    parameter int PERIOD  = 30,   // clk cycles per UART bit
    parameter int PDM_DIV = 48,   // clk cycles per PDM clock period (even)
    parameter int FIFO_AW = 4     // FIFO depth = 2**FIFO_AW bytes
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic pdm_data,
    output logic pdm_clk,
    output logic tx,
    output logic overflow,
    output logic busy
);
    localparam int HALF   = PDM_DIV / 2;
    localparam int DIV_W  = (PDM_DIV > 2) ? $clog2(PDM_DIV) : 1;
    localparam int BAUD_W = $clog2(PERIOD);
    localparam int DEPTH  = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // PDM clock and capture
    logic [DIV_W-1:0]  div_cnt_reg;
    logic              pdm_clk_reg;
    logic [7:0]        shift_reg;
    logic [2:0]        sample_cnt_reg;
    logic              wr_req_reg;
    logic [7:0]        wr_data_reg;
    logic              sample_tick;

    // FIFO
    logic [FIFO_AW:0]  wr_ptr_reg, wr_ptr_next;
    logic [FIFO_AW:0]  rd_ptr_reg, rd_ptr_next;
    logic [7:0]        mem [DEPTH];
    logic              fifo_empty, fifo_full, do_write, pop;
    logic              overflow_reg;

    // UART
    state_t            state_reg, state_next;
    logic [BAUD_W-1:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]        bit_idx_reg, bit_idx_next;
    logic [7:0]        tx_byte_reg;
    logic              tx_reg, tx_next;
    logic              busy_reg, busy_next;
    logic              baud_end;

    // The last high cycle of pdm_clk is where the microphone data is taken.
    assign sample_tick = enable && (div_cnt_reg == DIV_W'(HALF - 1));

    // PDM clock divider: free-running while enabled, parked at 0 / low otherwise.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            div_cnt_reg <= '0;
            pdm_clk_reg <= 1'b0;
        end else begin
            pdm_clk_reg <= (div_cnt_reg < DIV_W'(HALF));
            if (div_cnt_reg == DIV_W'(PDM_DIV - 1)) begin
                div_cnt_reg <= '0;
            end else begin
                div_cnt_reg <= div_cnt_reg + DIV_W'(1);
            end
        end
    end

    // Sample shifter: a partial byte is thrown away when capture stops.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            shift_reg      <= '0;
            sample_cnt_reg <= '0;
        end else if (sample_tick) begin
            shift_reg      <= {shift_reg[6:0], pdm_data};
            sample_cnt_reg <= sample_cnt_reg + 3'd1;
        end
    end

    // Completed byte is staged one cycle, so it survives an enable drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_req_reg  <= 1'b0;
            wr_data_reg <= '0;
        end else begin
            wr_req_reg <= sample_tick && (sample_cnt_reg == 3'd7);
            if (sample_tick && (sample_cnt_reg == 3'd7)) begin
                wr_data_reg <= {shift_reg[6:0], pdm_data};
            end
        end
    end

    assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full   = (wr_ptr_reg[FIFO_AW] != rd_ptr_reg[FIFO_AW]) &&
                         (wr_ptr_reg[FIFO_AW-1:0] == rd_ptr_reg[FIFO_AW-1:0]);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_write    = wr_req_reg && (!fifo_full || pop);
    assign wr_ptr_next = do_write ? wr_ptr_reg + (FIFO_AW + 1)'(1) : wr_ptr_reg;
    assign rd_ptr_next = pop ? rd_ptr_reg + (FIFO_AW + 1)'(1) : rd_ptr_reg;

    // FIFO storage write port (no reset so it maps onto block RAM).
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_reg[FIFO_AW-1:0]] <= wr_data_reg;
        end
    end

    // FIFO registered read port doubles as the UART transmit byte holder.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_byte_reg <= '0;
        end else if (pop) begin
            tx_byte_reg <= mem[rd_ptr_reg[FIFO_AW-1:0]];
        end
    end

    // FIFO pointers and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            if (wr_req_reg && !do_write) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign baud_end = (baud_cnt_reg == BAUD_W'(PERIOD - 1));

    // UART next-state, next-output and FIFO pop decision.
    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        tx_next       = tx_reg;
        pop           = 1'b0;
        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    state_next    = START;
                    baud_cnt_next = '0;
                    tx_next       = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_next    = DATA;
                    baud_cnt_next = '0;
                    bit_idx_next  = 3'd0;
                    tx_next       = tx_byte_reg[0];
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_cnt_next = '0;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        tx_next      = tx_byte_reg[bit_idx_next];
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_cnt_next = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
        busy_next = (state_next != IDLE) || (wr_ptr_next != rd_ptr_next);
    end

    // UART state register; busy is computed from next state so it tracks IDLE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
        end
    end

    assign pdm_clk  = pdm_clk_reg;
    assign tx       = tx_reg;
    assign overflow = overflow_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_pdm_uart_tx.sv
// Directed testbench for pdm_uart_tx with PERIOD=4, PDM_DIV=4.
module tb_pdm_uart_tx;
    localparam int P = 4;
    localparam int D = 4;

    logic clk;
    logic rst;
    logic enable;
    logic pdm_data;
    logic pdm_clk;
    logic tx;
    logic overflow;
    logic busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    pdm_uart_tx #(.PERIOD(P), .PDM_DIV(D), .FIFO_AW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .pdm_data (pdm_data),
        .pdm_clk  (pdm_clk),
        .tx       (tx),
        .overflow (overflow),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Feed n samples MSB first from a fresh (parked) divider; returns just
    // after the clock edge that takes the last sample.
    task automatic send_bits(input logic [7:0] b, input int n);
        @(negedge clk);
        enable   = 1'b1;
        pdm_data = b[7];
        repeat (D / 2) @(posedge clk);
        for (int j = 1; j < n; j++) begin
            @(negedge clk);
            pdm_data = b[7 - j];
            repeat (D) @(posedge clk);
        end
    endtask

    // Decode one 8N1 frame sampling every cycle; must be called at a negedge.
    // Returns at the negedge of the last stop-bit cycle.
    task automatic get_frame(input int timeout, output logic [7:0] data,
                             output bit found, output bit ok, output int t0);
        int n;
        int slot;
        n = 0;
        data = '0;
        found = 1'b0;
        ok = 1'b1;
        t0 = 0;
        while (tx !== 1'b0 && n < timeout) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        found = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 10 * P; i++) begin
            slot = i / P;
            if (slot == 0) begin
                if (tx !== 1'b0) ok = 1'b0;
            end else if (slot == 9) begin
                if (tx !== 1'b1) ok = 1'b0;
            end else if (i % P == 0) begin
                data[slot - 1] = tx;
            end else if (tx !== data[slot - 1]) begin
                ok = 1'b0;
            end
            if (i != 10 * P - 1) @(negedge clk);
        end
        $display("frame t=%0d data=%02h %s", t0, data, ok ? "well-formed" : "malformed");
    endtask

    // Count cycles over a window where the line is active or busy is set.
    task automatic quiet_window(input int len, output int activity);
        activity = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) activity++;
        end
    endtask

    initial begin
        logic [7:0] data;
        bit found;
        bit ok;
        int t0;
        int prev_t0;
        int n;
        int act;

        rst = 1'b1;
        enable = 1'b1;
        pdm_data = 1'b0;

        // Reset held 5 cycles with enable high
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_tx", tx, 1);
            check("rst_pdm_clk", pdm_clk, 0);
            check("rst_overflow", overflow, 0);
            check("rst_busy", busy, 0);
        end
        rst = 1'b0;
        // pdm_clk: high for first half of each period, low for second
        for (int k = 0; k < 2 * D; k++) begin
            @(negedge clk);
            check("pdm_clk_wave", pdm_clk, ((k % D) < D / 2) ? 1 : 0);
        end
        enable = 1'b0;
        @(negedge clk);
        check("pdm_clk_stop", pdm_clk, 0);
        quiet_window(10, act);
        check("partial_discard", act, 0);

        // Single byte 0xA5
        send_bits(8'hA5, 8);
        @(negedge clk);
        enable = 1'b0;
        check("lat_s1", tx, 1);
        @(negedge clk);
        check("lat_s2", tx, 1);
        @(negedge clk);
        check("lat_s3_fall", tx, 0);
        get_frame(4, data, found, ok, t0);
        check("a5_found", found, 1);
        check("a5_ok", ok, 1);
        check("a5_data", data, 8'hA5);
        check("a5_busy_stop", busy, 1);
        @(negedge clk);
        check("a5_busy_end", busy, 0);
        check("a5_tx_idle", tx, 1);

        // Enable abort after 3 samples
        send_bits(8'hFF, 3);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_pdm_clk", pdm_clk, 0);
        quiet_window(60, act);
        check("abort_no_frame", act, 0);
        send_bits(8'hC3, 8);
        @(negedge clk);
        enable = 1'b0;
        get_frame(10, data, found, ok, t0);
        check("c3_found", found, 1);
        check("c3_ok", ok, 1);
        check("c3_data", data, 8'hC3);
        @(negedge clk);
        quiet_window(80, act);
        check("c3_single", act, 0);

        // Back-to-back 0xFF frames
        @(negedge clk);
        enable = 1'b1;
        pdm_data = 1'b1;
        prev_t0 = 0;
        for (int i = 0; i < 8; i++) begin
            get_frame(60, data, found, ok, t0);
            check("b2b_found", found, 1);
            check("b2b_ok", ok, 1);
            check("b2b_data", data, 8'hFF);
            if (i > 0) check("b2b_gap", t0 - prev_t0, 10 * P);
            prev_t0 = t0;
        end
        check("b2b_overflow", overflow, 0);
        enable = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("b2b_drain", busy, 0);

        // Overflow: zeros faster than the link drains them
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
        pdm_data = 1'b0;
        n = 0;
        while (overflow !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("ovf_set", overflow, 1);
        enable = 1'b0;
        n = 0;
        while (tx !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        prev_t0 = 0;
        for (int i = 0; i < 40; i++) begin
            get_frame(20 * P, data, found, ok, t0);
            if (!found) break;
            n++;
            check("ovf_frame_ok", ok, 1);
            check("ovf_frame_data", data, 8'h00);
            if (n > 1) check("ovf_gap", t0 - prev_t0, 10 * P);
            prev_t0 = t0;
        end
        check("ovf_count_ge16", (n >= 16) ? 1 : 0, 1);
        check("ovf_sticky", overflow, 1);
        check("ovf_busy_end", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Reset during DATA bit 3
        send_bits(8'hA5, 8);
        @(negedge clk);
        enable = 1'b0;
        n = 0;
        while (tx !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("mid_start", tx, 0);
        repeat (4 * P + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        quiet_window(100, act);
        check("mid_rst_quiet", act, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
